// File: rtl/flopr.sv
`default_nettype none
// ============================================================================
// Module   : flopr
// Purpose  : N-bit D register, rising-edge capture, asynchronous active-high
//            reset that clears q to zero.
// Revision : 1.0  initial release
// ============================================================================
module flopr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Reset sits in the sensitivity list so clearing never waits for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flopr.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for flopr: a reference model checked every half cycle, plus
// hand-computed expectations at fixed times for the N=4 and N=8 instances.
module tb_flopr;

    logic       clk = 1'b1;
    logic       reset;
    logic [3:0] d4;
    logic [3:0] q4;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks = 0;
    int errors = 0;

    flopr #(.N(4)) dut4 (.clk(clk), .reset(reset), .d(d4), .q(q4));
    flopr #(.N(8)) dut8 (.clk(clk), .reset(reset), .d(d8), .q(q8));

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: q is zero if reset is high now, was high at the last
    // edge, or rose since it; otherwise q is whatever d was at the last edge.
    logic [3:0] m_d4;
    logic [7:0] m_d8;
    logic       m_rst;
    logic       rst_seen = 1'b0;
    logic       valid    = 1'b0;

    always @(posedge reset) rst_seen = 1'b1;

    task automatic model_compare(input string tag);
        logic       zero;
        zero = reset || m_rst || rst_seen;
        check({tag, "_q4"}, {4'h0, q4}, zero ? 8'h00 : {4'h0, m_d4});
        check({tag, "_q8"}, q8,         zero ? 8'h00 : m_d8);
    endtask

    always @(posedge clk) begin
        m_d4     = d4;
        m_d8     = d8;
        m_rst    = reset;
        rst_seen = 1'b0;
        valid    = 1'b1;
        #10;
        model_compare("model_rise");
    end

    always @(negedge clk) begin
        #10;
        if (valid) model_compare("model_fall");
    end

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        reset = 1'b1;
        d4    = 4'h0;
        d8    = 8'h00;

        // Power-up reset held through the first edge, released between edges.
        wait_until(110);  check("pwr_reset",       {4'h0, q4}, 8'h00);
        wait_until(125);  reset = 1'b0;
        wait_until(150);  d4 = 4'h1;
        wait_until(160);  check("post_release",    {4'h0, q4}, 8'h00);

        // Incrementing stream.
        wait_until(210);  check("stream_1",        {4'h0, q4}, 8'h01);
        wait_until(250);  d4 = 4'h2;
        wait_until(310);  check("stream_2",        {4'h0, q4}, 8'h02);
        wait_until(350);  d4 = 4'h3;
        wait_until(410);  check("stream_3",        {4'h0, q4}, 8'h03);
        wait_until(450);  d4 = 4'h4;
        wait_until(510);  check("stream_4",        {4'h0, q4}, 8'h04);

        // Hold between edges.
        wait_until(550);  d4 = 4'h5;
        wait_until(610);  check("hold_5",          {4'h0, q4}, 8'h05);
        wait_until(650);  d4 = 4'hA;
        wait_until(660);  check("hold_mid",        {4'h0, q4}, 8'h05);
        wait_until(710);  check("hold_A",          {4'h0, q4}, 8'h0A);

        // Asynchronous reset mid-cycle, held across two edges.
        wait_until(750);  d4 = 4'hF;
        wait_until(810);  check("pre_reset_F",     {4'h0, q4}, 8'h0F);
        wait_until(820);  reset = 1'b1;
        wait_until(830);  check("async_clear",     {4'h0, q4}, 8'h00);
        wait_until(850);  d4 = 4'h7;
        wait_until(910);  check("reset_hold_1",    {4'h0, q4}, 8'h00);
        wait_until(950);  d4 = 4'h9;
        wait_until(1010); check("reset_hold_2",    {4'h0, q4}, 8'h00);

        // Release mid-cycle, then capture.
        wait_until(1025); reset = 1'b0;
        wait_until(1060); check("release_wait",    {4'h0, q4}, 8'h00);
        wait_until(1110); check("release_capture", {4'h0, q4}, 8'h09);

        // Bit independence patterns on both widths.
        wait_until(1150); d4 = 4'b1010; d8 = 8'hA5;
        wait_until(1210); check("bits_1010", {4'h0, q4}, 8'h0A);
                          check("bits8_A5",  q8,         8'hA5);
        wait_until(1250); d4 = 4'b0101; d8 = 8'h5A;
        wait_until(1310); check("bits_0101", {4'h0, q4}, 8'h05);
                          check("bits8_5A",  q8,         8'h5A);
        wait_until(1350); d4 = 4'hF;    d8 = 8'hFF;
        wait_until(1410); check("bits_ones", {4'h0, q4}, 8'h0F);
                          check("bits8_FF",  q8,         8'hFF);
        wait_until(1450); d4 = 4'h0;    d8 = 8'h00;
        wait_until(1510); check("bits_zero", {4'h0, q4}, 8'h00);
                          check("bits8_00",  q8,         8'h00);

        wait_until(1580);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
